vram_dma_master: RTL
====================

# vram_dma_master

Bus initiator that copies data from system memory into LCD RAM (VRAM) using the GBC HDMA model: general-purpose bulk copy, or one 16-byte block per H-blank. It sits between the MMU's HDMA register file and the LCD RAM bus, driving the active-low strobe / shared-data protocol the LCD RAM responds to. During a transfer it asserts a CPU stall.

## Interface
- READ_LATENCY, 2, cycles from source address/RE_L presented to I_SRC_DATA valid (≥1)
- I_MEM_CLK  in  1  memory clock, all state on rising edge
- I_RESET  in  1  asynchronous, active-high reset
- I_SRC_ADDR  in  16  source start; bits [3:0] ignored (treated 0)
- I_DST_ADDR  in  13  VRAM offset; bits [3:0] ignored (treated 0)
- I_BLOCKS  in  7  length = (I_BLOCKS+1)×16 bytes
- I_MODE  in  1  0 = general-purpose, 1 = H-blank
- I_START  in  1  one-cycle start pulse; samples I_SRC_ADDR/I_DST_ADDR/I_BLOCKS/I_MODE
- I_CANCEL  in  1  one-cycle cancel request (H-blank mode only)
- I_HBLANK  in  1  one-cycle pulse at H-blank entry
- O_SRC_ADDR  out  16  source read address
- O_SRC_RE_L  out  1  source read strobe, active low
- I_SRC_DATA  in  8  source read data
- O_LCDRAM_ADDR  out  16  = 16'h8000 | dst
- IO_LCDRAM_DATA  inout  8  driven only while writing, else high-Z
- O_LCDRAM_WE_L  out  1  write strobe, active low
- O_LCDRAM_RE_L  out  1  tied high (never reads)
- O_BUSY  out  1  transfer active (any state but IDLE)
- O_CPU_STALL  out  1  high in RD, WR, BLK_END
- O_BLOCKS_LEFT  out  7  remaining blocks − 1; 7'h7F when idle

## Operation
- States: IDLE, WAIT_HB, RD, WR, BLK_END.
- IDLE: I_START → latch src = {I_SRC_ADDR[15:4],4'h0}, dst = {I_DST_ADDR[12:4],4'h0}, left = I_BLOCKS, byte = 0; next state RD if I_MODE=0, WAIT_HB if 1.
- WAIT_HB: I_HBLANK → RD; I_CANCEL → IDLE immediately (cancel wins if both same cycle).
- RD: O_SRC_RE_L=0, O_SRC_ADDR=src, held READ_LATENCY cycles; clock edge ending last RD cycle loads data reg from I_SRC_DATA → WR.
- WR: one cycle, O_LCDRAM_WE_L=0, data reg on IO_LCDRAM_DATA, O_LCDRAM_ADDR=8000|dst; then src+=1, dst+=1, byte+=1; byte wraps 15→0 → BLK_END else RD.
- BLK_END: left==0 or pending cancel → IDLE (left := 7'h7F); else left−=1; next RD (general) or WAIT_HB (H-blank).
- Arithmetic: src wraps 16'hFFFF→0; dst wraps 13'h1FFF→0 (O_LCDRAM_ADDR stays in 8000–9FFF); byte counter 4 bits.
- I_START while busy: ignored. I_HBLANK outside WAIT_HB: ignored, not queued. I_CANCEL in general mode: ignored. I_CANCEL during RD/WR/BLK_END in H-blank mode: sets pending flag, current block completes, then IDLE.
- I_START coincident with I_HBLANK: H-blank not counted; first block waits for next pulse.

## Timing
- Reset (async): state IDLE; O_SRC_RE_L=1, O_LCDRAM_WE_L=1, O_LCDRAM_RE_L=1, IO_LCDRAM_DATA=Z, O_SRC_ADDR=0, O_LCDRAM_ADDR=16'h8000, O_BUSY=0, O_CPU_STALL=0, O_BLOCKS_LEFT=7'h7F, cancel flag 0. Reset mid-WR aborts that write immediately; no partial completion.
- Byte cost READ_LATENCY+1 cycles; block cost 16×(READ_LATENCY+1)+1 (BLK_END). Default: 49 cycles/block.
- General mode: RD entered cycle after I_START; N blocks finish in N×49 cycles then IDLE.
- WE_L low exactly one cycle per byte; address/data stable that whole cycle; WE_L and SRC_RE_L never low together.
- All outputs registered.

## Structure
- Shared package: state enum, VRAM_BASE = 16'h8000, BLOCK_BYTES = 16, IDLE_BLOCKS_LEFT = 7'h7F.
- One natural sub-module: dma_byte_mover — per-byte RD/WR sequencer (latency counter, data register, strobes, tristate enable) with go/done handshake; top holds mode, block counting, cancel and address registers.

## Test plan
- General: src 16'hC123, dst 13'h0005, blocks 0, mode 0, pulse start → 16 writes to 8000–800F with bytes from C120–C12F, 49 stall cycles, O_BLOCKS_LEFT 7'h7F at end.
- H-blank: blocks 2, mode 1 → no activity until each I_HBLANK; one block per pulse; O_BLOCKS_LEFT 1, 0, 7F after blocks 1, 2, 3; stall only during blocks.
- Cancel: H-blank blocks 5, cancel in WAIT_HB → IDLE next cycle, zero writes; cancel mid-block 2 → block 2 completes (32 bytes total), then IDLE.
- Wrap: dst 13'h1FF0, src 16'hFFF0, blocks 1 → second block writes 8000–800F from 0000–000F.
- Ignored events: I_START and I_HBLANK pulses during RD/WR → transfer unchanged, no extra block; start+hblank same cycle → waits for next pulse.
- Reset mid-WR → WE_L high and data Z while reset asserted, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/vram_dma_master_pkg.sv
// Shared definitions for the VRAM DMA master: controller states, VRAM window
// constants and the VRAM address mapping helper.
package vram_dma_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HB,
        ST_RD,
        ST_WR,
        ST_BLK_END
    } dma_state_t;

    localparam logic [15:0] VRAM_BASE        = 16'h8000;
    localparam int          BLOCK_BYTES      = 16;
    localparam logic [3:0]  LAST_BYTE        = 4'(BLOCK_BYTES - 1);
    localparam logic [6:0]  IDLE_BLOCKS_LEFT = 7'h7F;

    // The 13-bit VRAM offset always lands inside the 8000-9FFF window.
    function automatic logic [15:0] vram_addr(input logic [12:0] dst);
        return VRAM_BASE | {3'b000, dst};
    endfunction

endpackage

// File: rtl/vram_dma_master_byte_mover.sv
// Per-byte read-then-write sequencer: holds the source read strobe for the read
// latency, captures the byte, then drives it onto the VRAM bus for one cycle.
module dma_byte_mover #(
    parameter int READ_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] src_data,
    output logic       rd_last,
    output logic       src_re_l,
    output logic       wr_we_l,
    output logic       wr_oe,
    output logic [7:0] wr_data
);

    localparam int             LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    logic             reading_q, reading_d;
    logic             writing_q, writing_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]       data_q, data_d;

    always_comb begin
        reading_d = reading_q;
        writing_d = 1'b0;
        lat_d     = lat_q;
        data_d    = data_q;
        if (go) begin
            reading_d = 1'b1;
            lat_d     = '0;
        end else if (reading_q) begin
            if (lat_q == LAT_LAST) begin
                // Source data is valid on this edge; hand straight over to the write cycle.
                reading_d = 1'b0;
                writing_d = 1'b1;
                data_d    = src_data;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reading_q <= 1'b0;
            writing_q <= 1'b0;
            lat_q     <= '0;
            data_q    <= '0;
        end else begin
            reading_q <= reading_d;
            writing_q <= writing_d;
            lat_q     <= lat_d;
            data_q    <= data_d;
        end
    end

    assign rd_last  = reading_q && (lat_q == LAT_LAST);
    assign src_re_l = ~reading_q;
    assign wr_we_l  = ~writing_q;
    assign wr_oe    = writing_q;
    assign wr_data  = data_q;

endmodule

// File: rtl/vram_dma_master.sv
// HDMA-style copy engine from system memory into VRAM: general-purpose bulk
// copy or one 16-byte block per H-blank, stalling the CPU while bytes move.
module vram_dma_master
    import vram_dma_master_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        I_MEM_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_SRC_ADDR,
    input  logic [12:0] I_DST_ADDR,
    input  logic [6:0]  I_BLOCKS,
    input  logic        I_MODE,
    input  logic        I_START,
    input  logic        I_CANCEL,
    input  logic        I_HBLANK,
    output logic [15:0] O_SRC_ADDR,
    output logic        O_SRC_RE_L,
    input  logic [7:0]  I_SRC_DATA,
    output logic [15:0] O_LCDRAM_ADDR,
    inout  wire  [7:0]  IO_LCDRAM_DATA,
    output logic        O_LCDRAM_WE_L,
    output logic        O_LCDRAM_RE_L,
    output logic        O_BUSY,
    output logic        O_CPU_STALL,
    output logic [6:0]  O_BLOCKS_LEFT
);

    dma_state_t  state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [12:0] dst_q, dst_d;
    logic [6:0]  left_q, left_d;
    logic [3:0]  byte_q, byte_d;
    logic        mode_q, mode_d;
    logic        cancel_q, cancel_d;
    logic        busy_q, busy_d;
    logic        stall_q, stall_d;

    logic        mv_go;
    logic        mv_rd_last;
    logic        mv_we_l;
    logic        mv_oe;
    logic [7:0]  mv_data;
    logic        cancel_req;

    // Cancel is only meaningful for H-blank transfers.
    assign cancel_req = I_CANCEL & mode_q;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        left_d   = left_q;
        byte_d   = byte_q;
        mode_d   = mode_q;
        cancel_d = cancel_q;
        mv_go    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    src_d    = I_SRC_ADDR & 16'hFFF0;
                    dst_d    = I_DST_ADDR & 13'h1FF0;
                    left_d   = I_BLOCKS;
                    byte_d   = 4'd0;
                    mode_d   = I_MODE;
                    cancel_d = 1'b0;
                    if (I_MODE) begin
                        state_d = ST_WAIT_HB;
                    end else begin
                        state_d = ST_RD;
                        mv_go   = 1'b1;
                    end
                end
            end
            ST_WAIT_HB: begin
                if (I_CANCEL) begin
                    state_d  = ST_IDLE;
                    left_d   = IDLE_BLOCKS_LEFT;
                    cancel_d = 1'b0;
                end else if (I_HBLANK) begin
                    state_d = ST_RD;
                    mv_go   = 1'b1;
                end
            end
            ST_RD: begin
                if (cancel_req) begin
                    cancel_d = 1'b1;
                end
                if (mv_rd_last) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (cancel_req) begin
                    cancel_d = 1'b1;
                end
                src_d  = src_q + 16'd1;
                dst_d  = dst_q + 13'd1;
                byte_d = byte_q + 4'd1;
                if (byte_q == LAST_BYTE) begin
                    state_d = ST_BLK_END;
                end else begin
                    state_d = ST_RD;
                    mv_go   = 1'b1;
                end
            end
            ST_BLK_END: begin
                // A cancel landing on this very cycle is honoured like a pending one.
                if ((left_q == 7'd0) || cancel_q || cancel_req) begin
                    state_d  = ST_IDLE;
                    left_d   = IDLE_BLOCKS_LEFT;
                    cancel_d = 1'b0;
                end else begin
                    left_d = left_q - 7'd1;
                    if (mode_q) begin
                        state_d = ST_WAIT_HB;
                    end else begin
                        state_d = ST_RD;
                        mv_go   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with the strobes.
    assign busy_d  = (state_d != ST_IDLE);
    assign stall_d = (state_d == ST_RD) || (state_d == ST_WR) || (state_d == ST_BLK_END);

    always_ff @(posedge I_MEM_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q  <= ST_IDLE;
            src_q    <= 16'h0000;
            dst_q    <= 13'h0000;
            left_q   <= IDLE_BLOCKS_LEFT;
            byte_q   <= 4'd0;
            mode_q   <= 1'b0;
            cancel_q <= 1'b0;
            busy_q   <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            left_q   <= left_d;
            byte_q   <= byte_d;
            mode_q   <= mode_d;
            cancel_q <= cancel_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
        end
    end

    dma_byte_mover #(
        .READ_LATENCY(READ_LATENCY)
    ) u_mover (
        .clk      (I_MEM_CLK),
        .rst      (I_RESET),
        .go       (mv_go),
        .src_data (I_SRC_DATA),
        .rd_last  (mv_rd_last),
        .src_re_l (O_SRC_RE_L),
        .wr_we_l  (mv_we_l),
        .wr_oe    (mv_oe),
        .wr_data  (mv_data)
    );

    assign O_SRC_ADDR     = src_q;
    assign O_LCDRAM_ADDR  = vram_addr(dst_q);
    assign O_LCDRAM_WE_L  = mv_we_l;
    assign O_LCDRAM_RE_L  = 1'b1;
    assign IO_LCDRAM_DATA = mv_oe ? mv_data : 8'hzz;
    assign O_BUSY         = busy_q;
    assign O_CPU_STALL    = stall_q;
    assign O_BLOCKS_LEFT  = left_q;

endmodule
